mem_copy_engine: RTL and testbench
==================================

// Module: mem_copy_engine
// PURPOSE
//   Block-copy controller for the 2R/1W data memory. Copies LEN words from SRC to DST,
//   one word per cycle, using read port 1 and the write port. The CPU keeps read port 0.
//   Sits between the CPU datapath and the memory, and muxes the CPU's port-1/write
//   signals with its own. CPU writes always win the write port; the engine stalls on those.
// PARAMETERS
//   N_ELEMENTS  128  memory depth in words; legal addresses are 0..N_ELEMENTS-1
//   ADDR_WIDTH  16   address width (bits)
//   DATA_WIDTH  16   data width (bits)
// PORTS
//   clk          in   1           clock; all state updates on posedge
//   rst          in   1           synchronous, active-high reset
//   start        in   1           copy request; sampled only in IDLE
//   src          in   ADDR_WIDTH  source base address; sampled with start
//   dst          in   ADDR_WIDTH  destination base address; sampled with start
//   len          in   ADDR_WIDTH  word count; sampled with start
//   busy         out  1           high in COPY
//   done         out  1           1-cycle pulse when a copy completes
//   err          out  1           1-cycle pulse when a request is rejected
//   cpu_r_addr_1 in   ADDR_WIDTH  CPU read address, port 1
//   cpu_w_addr   in   ADDR_WIDTH  CPU write address
//   cpu_w_data   in   DATA_WIDTH  CPU write data
//   cpu_w_en     in   1           CPU write enable
//   mem_r_addr_1 out  ADDR_WIDTH  to memory r_addr_1
//   mem_r_data_1 in   DATA_WIDTH  from memory r_data_1 (combinational read)
//   mem_w_addr   out  ADDR_WIDTH  to memory w_addr
//   mem_w_data   out  DATA_WIDTH  to memory w_data
//   mem_w_en     out  1           to memory w_en
// BEHAVIOUR
//   States: IDLE, COPY, DONE, ERR. Reset -> IDLE. busy/done/err are 0 after reset.
//   Registers cleared on reset: src_q, dst_q, cnt, dir.
//   IDLE, start=1:
//     - If src+len > N_ELEMENTS or dst+len > N_ELEMENTS, go to ERR.
//       Compute these sums at ADDR_WIDTH+1 bits so there is no wrap.
//     - Else if len==0, go to DONE.
//     - Else latch src/dst/len and go to COPY.
//   Direction: dir=DOWN iff dst>src (overlap safe); otherwise dir=UP.
//     - UP: offset k runs 0..len-1.
//     - DOWN: offset k runs len-1..0.
//   COPY, each cycle:
//     - mem_r_addr_1 = src_q+k.
//     - If cpu_w_en=0: mem_w_en=1, mem_w_addr=dst_q+k, mem_w_data=mem_r_data_1. Then advance k.
//     - If cpu_w_en=1: the CPU write passes through, and k holds (stall).
//     - After the word at the final offset is written, go to DONE.
//   Throughput is len words in len + (stall cycles) cycles; len=1 uses one COPY cycle.
//   DONE: done=1 for one cycle, then IDLE. ERR: err=1 for one cycle, then IDLE. No memory writes.
//   Outside COPY: mem_r_addr_1=cpu_r_addr_1, and the mem_w_* signals pass the cpu_w_* signals through.
//   In COPY, port 1 belongs to the engine; the CPU must not rely on port-1 reads while busy.
//   start is ignored in COPY, DONE and ERR; it is not queued.
//   Reset mid-copy: go to IDLE immediately. Words already written stay; no done pulse.
//   If src==dst, the copy still runs len cycles (rewriting the same data).
// TESTING
//   1. mem[10..13]=A,B,C,D; start src=10 dst=40 len=4 -> mem[40..43]=A..D; done 5 cycles after start.
//   2. Overlap: mem[20..23]=1,2,3,4; src=20 dst=22 len=4 -> mem[22..25]=1,2,3,4. Repeat with src=22 dst=20.
//   3. Stall: cpu_w_en=1 for 2 cycles mid-copy (cpu_w_addr=5, data=0xBEEF) -> mem[5]=0xBEEF; copy intact; done 2 cycles late.
//   4. Bounds: src=126 len=4 -> err pulse 1 cycle; no mem_w_en asserted. len=0 -> done next+1 cycle, no writes.
//   5. Reset at the 3rd COPY cycle of an 8-word copy -> busy=0 next cycle; exactly 2 destination words written; no done.
//   6. start held high through a copy -> exactly one copy; a new copy begins from IDLE after done.

Source files
------------

// File: rtl/mem_copy_engine_if.sv
// mem_copy_engine_if: control, CPU-side and memory-side signals of the block-copy engine
//   start/src/dst/len     copy request and its operands
//   busy/done/err         engine status (done/err are 1-cycle pulses)
//   cpu_r_addr_1, cpu_w_* CPU's port-1 read address and write port
//   mem_r_addr_1, mem_w_* muxed signals to the memory; mem_r_data_1 from the memory
//   slave modport is the engine, master modport is the CPU/memory side
interface mem_copy_engine_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16
);
   logic                  start;
   logic [ADDR_WIDTH-1:0] src;
   logic [ADDR_WIDTH-1:0] dst;
   logic [ADDR_WIDTH-1:0] len;
   logic                  busy;
   logic                  done;
   logic                  err;
   logic [ADDR_WIDTH-1:0] cpu_r_addr_1;
   logic [ADDR_WIDTH-1:0] cpu_w_addr;
   logic [DATA_WIDTH-1:0] cpu_w_data;
   logic                  cpu_w_en;
   logic [ADDR_WIDTH-1:0] mem_r_addr_1;
   logic [DATA_WIDTH-1:0] mem_r_data_1;
   logic [ADDR_WIDTH-1:0] mem_w_addr;
   logic [DATA_WIDTH-1:0] mem_w_data;
   logic                  mem_w_en;
   modport slave (
      input  start, src, dst, len, cpu_r_addr_1, cpu_w_addr, cpu_w_data, cpu_w_en, mem_r_data_1,
      output busy, done, err, mem_r_addr_1, mem_w_addr, mem_w_data, mem_w_en
   );
   modport master (
      output start, src, dst, len, cpu_r_addr_1, cpu_w_addr, cpu_w_data, cpu_w_en, mem_r_data_1,
      input  busy, done, err, mem_r_addr_1, mem_w_addr, mem_w_data, mem_w_en
   );
endinterface

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: copies len words from src to dst through memory read port 1 and the write port
//   clk, rst  clock and synchronous active-high reset
//   bus       mem_copy_engine_if.slave: request/status, CPU port-1/write signals, memory signals
module mem_copy_engine #(
   parameter int N_ELEMENTS = 128,
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16
) (
   input logic              clk,
   input logic              rst,
   mem_copy_engine_if.slave bus
);
   typedef enum logic [1:0] {IDLE, COPY, DONE, ERR} state_t;
   localparam logic [ADDR_WIDTH:0]   LIMIT = (ADDR_WIDTH+1)'(N_ELEMENTS);
   localparam logic [ADDR_WIDTH-1:0] ONE   = ADDR_WIDTH'(1);
   state_t                state;
   logic [ADDR_WIDTH-1:0] src_q, dst_q, cnt;
   logic                  dir, busy_q, done_q, err_q;
   logic                  oob, down, eng_we;
   logic [DATA_WIDTH-1:0] w_data;
   // one extra bit so base+len cannot wrap back into range
   assign oob = ({1'b0, bus.src} + {1'b0, bus.len} > LIMIT) || ({1'b0, bus.dst} + {1'b0, bus.len} > LIMIT);
   // copying top-down when dst is above src keeps overlapping copies correct
   assign down = bus.dst > bus.src;
   // a reset arriving mid-copy must not complete the word in flight
   assign eng_we = state == COPY && !bus.cpu_w_en && !rst;
   assign w_data = eng_we ? bus.mem_r_data_1 : bus.cpu_w_data;
   assign bus.mem_r_addr_1 = state == COPY ? src_q : bus.cpu_r_addr_1;
   assign bus.mem_w_en = bus.cpu_w_en || eng_we;
   assign bus.mem_w_addr = eng_we ? dst_q : bus.cpu_w_addr;
   assign bus.mem_w_data = w_data;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.err = err_q;
   // src_q/dst_q walk as live pointers; cnt holds the words still to write
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         src_q  <= '0;
         dst_q  <= '0;
         cnt    <= '0;
         dir    <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state)
            IDLE: if (bus.start) begin
               if (oob) begin
                  state <= ERR;
                  err_q <= 1'b1;
               end else if (bus.len == '0) begin
                  state  <= DONE;
                  done_q <= 1'b1;
               end else begin
                  state  <= COPY;
                  busy_q <= 1'b1;
                  dir    <= down;
                  src_q  <= down ? bus.src + bus.len - ONE : bus.src;
                  dst_q  <= down ? bus.dst + bus.len - ONE : bus.dst;
                  cnt    <= bus.len;
               end
            end
            COPY: if (!bus.cpu_w_en) begin
               src_q <= dir ? src_q - ONE : src_q + ONE;
               dst_q <= dir ? dst_q - ONE : dst_q + ONE;
               cnt   <= cnt - ONE;
               if (cnt == ONE) begin
                  state  <= DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: directed checks of mem_copy_engine against a 128-word memory model
module tb_mem_copy_engine;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_assert = 0;
   int   n_fail = 0;
   int   wcnt = 0;
   int   dcnt = 0;
   logic [15:0] mem [0:127];
   mem_copy_engine_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();
   mem_copy_engine #(.N_ELEMENTS(128), .ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   always #5 clk = ~clk;
   assign bus.mem_r_data_1 = mem[bus.mem_r_addr_1[6:0]];
   always @(posedge clk) begin
      if (bus.mem_w_en) mem[bus.mem_w_addr[6:0]] <= bus.mem_w_data;
      if (bus.mem_w_en) wcnt++;
      if (bus.done) dcnt++;
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
      bus.cpu_w_addr = a;
      bus.cpu_w_data = d;
      bus.cpu_w_en = 1'b1;
      tick();
      bus.cpu_w_en = 1'b0;
   endtask
   task automatic go(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
      bus.src = s;
      bus.dst = d;
      bus.len = l;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask
   // cyc counts cycles since the start cycle; returns at the done cycle or at the bound
   task automatic wait_done(input int from, output int cyc);
      cyc = from;
      while (!bus.done && cyc < 200) begin
         tick();
         cyc++;
      end
   endtask
   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      n_assert++;
      if ({bus.busy, bus.done, bus.err} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_status: got %b expected 000", {bus.busy, bus.done, bus.err});
      end
      bus.cpu_r_addr_1 = 16'd7;
      bus.cpu_w_addr = 16'd3;
      bus.cpu_w_data = 16'h1234;
      bus.cpu_w_en = 1'b1;
      #1;
      n_assert++;
      if (bus.mem_r_addr_1 !== 16'd7) begin
         n_fail++;
         $display("FAIL idle_raddr_pass: got %h expected 0007", bus.mem_r_addr_1);
      end
      n_assert++;
      if ({bus.mem_w_en, bus.mem_w_addr, bus.mem_w_data} !== {1'b1, 16'd3, 16'h1234}) begin
         n_fail++;
         $display("FAIL idle_write_pass: got %b/%h/%h expected 1/0003/1234", bus.mem_w_en, bus.mem_w_addr, bus.mem_w_data);
      end
      tick();
      bus.cpu_w_en = 1'b0;
      #1;
      n_assert++;
      if (bus.mem_w_en !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_wen_low: got %b expected 0", bus.mem_w_en);
      end
   endtask
   task automatic test_basic();
      logic [15:0] exp [4] = '{16'hA0A0, 16'hB1B1, 16'hC2C2, 16'hD3D3};
      int cyc;
      for (int i = 0; i < 4; i++) cpu_write(16'(10 + i), exp[i]);
      go(16'd10, 16'd40, 16'd4);
      n_assert++;
      if (bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_busy: got %b expected 1", bus.busy);
      end
      n_assert++;
      if (bus.mem_r_addr_1 !== 16'd13) begin
         n_fail++;
         $display("FAIL basic_first_raddr: got %h expected 000d", bus.mem_r_addr_1);
      end
      wait_done(1, cyc);
      n_assert++;
      if (cyc !== 5) begin
         n_fail++;
         $display("FAIL basic_latency: got %0d expected 5", cyc);
      end
      tick();
      n_assert++;
      if ({bus.done, bus.busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL basic_done_pulse: got %b expected 00", {bus.done, bus.busy});
      end
      for (int i = 0; i < 4; i++) begin
         n_assert++;
         if (mem[40 + i] !== exp[i]) begin
            n_fail++;
            $display("FAIL basic_mem[%0d]: got %h expected %h", 40 + i, mem[40 + i], exp[i]);
         end
      end
   endtask
   task automatic test_overlap();
      logic [15:0] up_exp [6] = '{16'd5, 16'd6, 16'd7, 16'd8, 16'd7, 16'd8};
      int cyc;
      for (int i = 0; i < 4; i++) cpu_write(16'(20 + i), 16'(i + 1));
      go(16'd20, 16'd22, 16'd4);
      wait_done(1, cyc);
      tick();
      for (int i = 0; i < 6; i++) begin
         n_assert++;
         if (mem[20 + i] !== 16'(i < 2 ? i + 1 : i - 1)) begin
            n_fail++;
            $display("FAIL overlap_down_mem[%0d]: got %h expected %h", 20 + i, mem[20 + i], 16'(i < 2 ? i + 1 : i - 1));
         end
      end
      for (int i = 0; i < 4; i++) cpu_write(16'(22 + i), 16'(i + 5));
      go(16'd22, 16'd20, 16'd4);
      wait_done(1, cyc);
      tick();
      for (int i = 0; i < 6; i++) begin
         n_assert++;
         if (mem[20 + i] !== up_exp[i]) begin
            n_fail++;
            $display("FAIL overlap_up_mem[%0d]: got %h expected %h", 20 + i, mem[20 + i], up_exp[i]);
         end
      end
   endtask
   task automatic test_stall();
      int cyc;
      for (int i = 0; i < 4; i++) cpu_write(16'(30 + i), 16'(16'h1111 * (i + 1)));
      go(16'd30, 16'd50, 16'd4);
      tick();
      bus.cpu_w_addr = 16'd5;
      bus.cpu_w_data = 16'hBEEF;
      bus.cpu_w_en = 1'b1;
      #1;
      n_assert++;
      if ({bus.mem_w_en, bus.mem_w_addr, bus.mem_w_data} !== {1'b1, 16'd5, 16'hBEEF}) begin
         n_fail++;
         $display("FAIL stall_cpu_wins: got %b/%h/%h expected 1/0005/beef", bus.mem_w_en, bus.mem_w_addr, bus.mem_w_data);
      end
      tick();
      tick();
      bus.cpu_w_en = 1'b0;
      n_assert++;
      if (bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_busy: got %b expected 1", bus.busy);
      end
      wait_done(4, cyc);
      n_assert++;
      if (cyc !== 7) begin
         n_fail++;
         $display("FAIL stall_latency: got %0d expected 7", cyc);
      end
      tick();
      n_assert++;
      if (mem[5] !== 16'hBEEF) begin
         n_fail++;
         $display("FAIL stall_cpu_word: got %h expected beef", mem[5]);
      end
      for (int i = 0; i < 4; i++) begin
         n_assert++;
         if (mem[50 + i] !== 16'(16'h1111 * (i + 1))) begin
            n_fail++;
            $display("FAIL stall_mem[%0d]: got %h expected %h", 50 + i, mem[50 + i], 16'(16'h1111 * (i + 1)));
         end
      end
   endtask
   task automatic test_bounds();
      int base;
      int cyc;
      base = wcnt;
      go(16'd126, 16'd0, 16'd4);
      n_assert++;
      if ({bus.err, bus.busy, bus.done} !== 3'b100) begin
         n_fail++;
         $display("FAIL bounds_src_err: got %b expected 100", {bus.err, bus.busy, bus.done});
      end
      tick();
      n_assert++;
      if (bus.err !== 1'b0) begin
         n_fail++;
         $display("FAIL bounds_err_pulse: got %b expected 0", bus.err);
      end
      go(16'd0, 16'd125, 16'd4);
      n_assert++;
      if (bus.err !== 1'b1) begin
         n_fail++;
         $display("FAIL bounds_dst_err: got %b expected 1", bus.err);
      end
      tick();
      go(16'd1, 16'd0, 16'hFFFF);
      n_assert++;
      if (bus.err !== 1'b1) begin
         n_fail++;
         $display("FAIL bounds_wrap_err: got %b expected 1", bus.err);
      end
      tick();
      go(16'd10, 16'd40, 16'd0);
      n_assert++;
      if ({bus.done, bus.busy, bus.err} !== 3'b100) begin
         n_fail++;
         $display("FAIL len0_done: got %b expected 100", {bus.done, bus.busy, bus.err});
      end
      tick();
      n_assert++;
      if (bus.done !== 1'b0) begin
         n_fail++;
         $display("FAIL len0_done_pulse: got %b expected 0", bus.done);
      end
      n_assert++;
      if (wcnt - base !== 0) begin
         n_fail++;
         $display("FAIL bounds_no_writes: got %0d writes expected 0", wcnt - base);
      end
      go(16'd124, 16'd64, 16'd4);
      n_assert++;
      if ({bus.busy, bus.err} !== 2'b10) begin
         n_fail++;
         $display("FAIL bounds_edge_accept: got %b expected 10", {bus.busy, bus.err});
      end
      wait_done(1, cyc);
      tick();
      n_assert++;
      if (cyc !== 5) begin
         n_fail++;
         $display("FAIL bounds_edge_latency: got %0d expected 5", cyc);
      end
   endtask
   task automatic test_same_addr();
      int base;
      int cyc;
      base = wcnt;
      go(16'd10, 16'd10, 16'd3);
      wait_done(1, cyc);
      tick();
      n_assert++;
      if (cyc !== 4 || wcnt - base !== 3) begin
         n_fail++;
         $display("FAIL same_addr: got %0d cycles %0d writes expected 4 cycles 3 writes", cyc, wcnt - base);
      end
      n_assert++;
      if (mem[11] !== 16'hB1B1) begin
         n_fail++;
         $display("FAIL same_addr_data: got %h expected b1b1", mem[11]);
      end
   endtask
   task automatic test_reset_mid();
      int wbase;
      int dbase;
      for (int i = 0; i < 3; i++) cpu_write(16'(80 + i), 16'(16'h8000 + i));
      cpu_write(16'd62, 16'hDEAD);
      go(16'd80, 16'd60, 16'd8);
      wbase = wcnt;
      dbase = dcnt;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_assert++;
      if (bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_busy: got %b expected 0", bus.busy);
      end
      n_assert++;
      if (wcnt - wbase !== 2) begin
         n_fail++;
         $display("FAIL rst_mid_writes: got %0d expected 2", wcnt - wbase);
      end
      n_assert++;
      if ({mem[60], mem[61], mem[62]} !== {16'h8000, 16'h8001, 16'hDEAD}) begin
         n_fail++;
         $display("FAIL rst_mid_mem: got %h %h %h expected 8000 8001 dead", mem[60], mem[61], mem[62]);
      end
      for (int i = 0; i < 8; i++) tick();
      n_assert++;
      if (dcnt - dbase !== 0) begin
         n_fail++;
         $display("FAIL rst_mid_no_done: got %0d done pulses expected 0", dcnt - dbase);
      end
   endtask
   task automatic test_start_held();
      int wbase;
      int dbase;
      int cyc;
      cpu_write(16'd100, 16'h0100);
      cpu_write(16'd101, 16'h0101);
      wbase = wcnt;
      dbase = dcnt;
      bus.src = 16'd100;
      bus.dst = 16'd110;
      bus.len = 16'd2;
      bus.start = 1'b1;
      tick();
      wait_done(1, cyc);
      n_assert++;
      if (cyc !== 3) begin
         n_fail++;
         $display("FAIL held_latency: got %0d expected 3", cyc);
      end
      tick();
      n_assert++;
      if (bus.busy !== 1'b0 || dcnt - dbase !== 1 || wcnt - wbase !== 2) begin
         n_fail++;
         $display("FAIL held_single_copy: got busy %b done %0d writes %0d expected 0 1 2", bus.busy, dcnt - dbase, wcnt - wbase);
      end
      tick();
      bus.start = 1'b0;
      n_assert++;
      if (bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL held_restart: got %b expected 1", bus.busy);
      end
      wait_done(1, cyc);
      tick();
      n_assert++;
      if (dcnt - dbase !== 2 || wcnt - wbase !== 4) begin
         n_fail++;
         $display("FAIL held_second_copy: got done %0d writes %0d expected 2 4", dcnt - dbase, wcnt - wbase);
      end
      n_assert++;
      if ({mem[110], mem[111]} !== {16'h0100, 16'h0101}) begin
         n_fail++;
         $display("FAIL held_mem: got %h %h expected 0100 0101", mem[110], mem[111]);
      end
   endtask
   initial begin
      bus.start = 1'b0;
      bus.src = '0;
      bus.dst = '0;
      bus.len = '0;
      bus.cpu_r_addr_1 = '0;
      bus.cpu_w_addr = '0;
      bus.cpu_w_data = '0;
      bus.cpu_w_en = 1'b0;
      test_reset();
      test_basic();
      test_overlap();
      test_stall();
      test_bounds();
      test_same_addr();
      test_reset_mid();
      test_start_held();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
